bus_regfile_sb: RTL and testbench

- Parametrised general-purpose register file for the bus-based datapath.
- Successor to the fixed 16-entry, single-enable register bank: configurable width and depth, two registered read ports, one write port, write-through bypass, optional hardwired-zero R0.
- Adds a per-register busy scoreboard so the control unit can stall reads of registers with a pending multi-cycle result (MUL/DIV, loads).
- Sits between the control unit, the bus mux inputs and the ALU/MDR writeback path.

---
 rtl/bus_regfile_sb.sv | 90 +++++++++
 tb/tb_bus_regfile_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_regfile_sb.sv
// Parametrised register file with two registered read ports, one write port,
// write-through bypass, optional hardwired-zero R0 and a per-register busy scoreboard.
module bus_regfile_sb #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 16,
    parameter  bit R0_ZERO    = 1'b1,
    parameter  bit BYPASS     = 1'b1,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  rd_en_a,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  rd_valid_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid_b,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_addr,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy_vec
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [DATA_WIDTH-1:0] rd_val_a;
    logic [DATA_WIDTH-1:0] rd_val_b;
    logic                  wr_eff;
    logic                  issue_eff;
    logic                  stall_a;
    logic                  stall_b;

    // Addresses that name a real, writable register (not out of range, not a hardwired R0).
    function automatic logic live_addr(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < NUM_REGS) && !(R0_ZERO && addr == ADDR_W'(0));
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_eff    = wr_en && live_addr(wr_addr);
        issue_eff = issue_en && live_addr(issue_addr);

        busy_next = busy;
        if (wr_eff)    busy_next[wr_addr]    = 1'b0;
        if (issue_eff) busy_next[issue_addr] = 1'b1;

        rd_val_a = '0;
        if (live_addr(rd_addr_a))
            rd_val_a = (BYPASS && wr_eff && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
        rd_val_b = '0;
        if (live_addr(rd_addr_b))
            rd_val_b = (BYPASS && wr_eff && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];

        // Without bypass the written value is not visible this edge, so the read must still wait.
        stall_a = rd_en_a && live_addr(rd_addr_a) && busy[rd_addr_a]
                  && !(BYPASS && wr_en && wr_addr == rd_addr_a);
        stall_b = rd_en_b && live_addr(rd_addr_b) && busy[rd_addr_b]
                  && !(BYPASS && wr_en && wr_addr == rd_addr_b);
        stall   = stall_a || stall_b;
    end

    // NOTE: the register array is reset here because a cleared register must read back as 0.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy       <= '0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every read below on the pre-edge state.
            if (wr_eff) regs[wr_addr] <= wr_data;
            busy       <= busy_next;
            rd_valid_a <= rd_en_a && !stall;
            rd_valid_b <= rd_en_b && !stall;
            if (rd_en_a && !stall) rd_data_a <= rd_val_a;
            if (rd_en_b && !stall) rd_data_b <= rd_val_b;
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_bus_regfile_sb.sv
// Randomised and directed checks of bus_regfile_sb (default parameters) against
// an array-based reference model of the register file and scoreboard.
module tb_bus_regfile_sb;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          rd_en_a = 1'b0, rd_en_b = 1'b0;
    logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          issue_en = 1'b0;
    logic [AW-1:0] issue_addr = '0;
    logic          stall;
    logic [NR-1:0] busy_vec;

    bus_regfile_sb dut (
        .clock(clock), .clear(clear),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clock = ~clock;

    // Reference model state
    int unsigned m_regs [NR];
    bit          m_busy [NR];
    int unsigned m_data_a, m_data_b;
    bit          m_valid_a, m_valid_b;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned busy_bits();
        int unsigned v = 0;
        for (int i = 0; i < NR; i++) if (m_busy[i]) v += (1 << i);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
        m_data_a = 0; m_data_b = 0; m_valid_a = 0; m_valid_b = 0;
    endfunction

    function automatic bit model_stall();
        bit s = 0;
        if (rd_en_a && m_busy[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a)) s = 1;
        if (rd_en_b && m_busy[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b)) s = 1;
        return s;
    endfunction

    function automatic int unsigned model_read(input int addr);
        if (addr == 0) return 0;
        if (wr_en && int'(wr_addr) == addr) return wr_data;
        return m_regs[addr];
    endfunction

    function automatic void model_edge();
        bit s = model_stall();
        m_valid_a = rd_en_a && !s;
        m_valid_b = rd_en_b && !s;
        if (m_valid_a) m_data_a = model_read(int'(rd_addr_a));
        if (m_valid_b) m_data_b = model_read(int'(rd_addr_b));
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 0;
        end
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".rd_data_a"},  64'(rd_data_a),  64'(m_data_a));
        check({tag, ".rd_data_b"},  64'(rd_data_b),  64'(m_data_b));
        check({tag, ".rd_valid_a"}, 64'(rd_valid_a), 64'(m_valid_a));
        check({tag, ".rd_valid_b"}, 64'(rd_valid_b), 64'(m_valid_b));
        check({tag, ".busy_vec"},   64'(busy_vec),   64'(busy_bits()));
    endtask

    // Inputs are applied #1 after a rising edge; stall is sampled on the falling edge.
    task automatic cycle(input string tag);
        @(negedge clock);
        check({tag, ".stall"}, 64'(stall), 64'(model_stall()));
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input bit ea, input int aa, input bit eb, input int ab,
                         input bit we, input int wa, input int unsigned wd,
                         input bit ie, input int ia);
        rd_en_a = ea; rd_addr_a = AW'(aa);
        rd_en_b = eb; rd_addr_b = AW'(ab);
        wr_en = we;   wr_addr = AW'(wa); wr_data = wd;
        issue_en = ie; issue_addr = AW'(ia);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #2;
        check_outputs("por");
        #10 clear = 1'b1;
        @(posedge clock); #1;

        // Asynchronous clear between edges wipes regs, scoreboard and read outputs
        drive(0, 0, 0, 0, 1, 4, 32'h0000_00FF, 1, 6); cycle("rst_setup");
        drive(1, 4, 1, 4, 0, 0, 0, 0, 0);              cycle("rst_read");
        #2 clear = 1'b0;
        #1 model_reset();
        check_outputs("rst_async");
        #1 clear = 1'b1;
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0); cycle("rst_r4");
        check("rst_r4_zero", 64'(rd_data_a), 64'h0);

        // Basic dual-port read
        drive(0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0); cycle("basic_wr");
        drive(1, 5, 1, 5, 0, 0, 0, 0, 0);              cycle("basic_rd");
        check("basic_a", 64'(rd_data_a), 64'hDEAD_BEEF);
        idle(); cycle("basic_idle");

        // Bypass of a same-edge write
        drive(0, 0, 0, 0, 1, 3, 32'h1111_1111, 0, 0); cycle("byp_wr");
        drive(1, 3, 0, 0, 1, 3, 32'h1234_5678, 0, 0); cycle("byp_rd");
        check("byp_a", 64'(rd_data_a), 64'h1234_5678);

        // Hardwired R0
        drive(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0); cycle("r0_wr");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);              cycle("r0_rd");
        check("r0_a", 64'(rd_data_a), 64'h0);

        // Scoreboard stall, then write satisfies the dependency
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7);              cycle("sb_issue");
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0);              cycle("sb_stall");
        drive(1, 7, 0, 0, 1, 7, 32'h0000_00A5, 0, 0);  cycle("sb_release");
        check("sb_a", 64'(rd_data_a), 64'hA5);

        // Issue and write on the same edge: new producer keeps the register busy
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9);              cycle("col_issue");
        drive(0, 0, 0, 0, 1, 9, 32'h42, 1, 9);         cycle("col_both");
        drive(0, 0, 1, 9, 0, 0, 0, 0, 0);              cycle("col_stall");
        drive(0, 0, 0, 0, 1, 9, 32'h77, 0, 0);         cycle("col_done");
        drive(0, 0, 1, 9, 0, 0, 0, 0, 0);              cycle("col_read");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, NR - 1),
                  $urandom_range(0, 1), $urandom_range(0, NR - 1),
                  ($urandom_range(0, 9) < 5), $urandom_range(0, NR - 1), $urandom,
                  ($urandom_range(0, 9) < 2), $urandom_range(0, NR - 1));
            if ($urandom_range(0, 7) == 0) rd_addr_b = rd_addr_a;
            if ($urandom_range(0, 7) == 0) wr_addr = rd_addr_a;
            cycle("rand");
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
